// File: rtl/alu_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// alu_pkg : shared ALUOp/funct codes, ALU operation codes and MDU state type
// Rev 1.0
// ---------------------------------------------------------------------------
package alu_pkg;

  localparam logic [2:0] ALUOP_ANDI  = 3'b000;
  localparam logic [2:0] ALUOP_ORI   = 3'b001;
  localparam logic [2:0] ALUOP_ADDI  = 3'b100;
  localparam logic [2:0] ALUOP_LUI   = 3'b101;
  localparam logic [2:0] ALUOP_RTYPE = 3'b111;

  localparam logic [5:0] FUNCT_AND   = 6'b100100;
  localparam logic [5:0] FUNCT_OR    = 6'b100101;
  localparam logic [5:0] FUNCT_NOR   = 6'b100111;
  localparam logic [5:0] FUNCT_ADD   = 6'b100000;
  localparam logic [5:0] FUNCT_SUB   = 6'b100010;
  localparam logic [5:0] FUNCT_SLL   = 6'b000000;
  localparam logic [5:0] FUNCT_SRL   = 6'b000010;
  localparam logic [5:0] FUNCT_SLT   = 6'b101010;
  localparam logic [5:0] FUNCT_MFHI  = 6'b010000;
  localparam logic [5:0] FUNCT_MFLO  = 6'b010010;
  localparam logic [5:0] FUNCT_MULTU = 6'b011001;
  localparam logic [5:0] FUNCT_DIVU  = 6'b011011;

  localparam logic [3:0] OP_AND   = 4'b0000;
  localparam logic [3:0] OP_OR    = 4'b0001;
  localparam logic [3:0] OP_NOR   = 4'b0010;
  localparam logic [3:0] OP_ADD   = 4'b0011;
  localparam logic [3:0] OP_SUB   = 4'b0100;
  localparam logic [3:0] OP_LUI   = 4'b0101;
  localparam logic [3:0] OP_SLL   = 4'b0110;
  localparam logic [3:0] OP_SRL   = 4'b0111;
  localparam logic [3:0] OP_SLT   = 4'b1000;
  localparam logic [3:0] OP_NOP   = 4'b1001;
  localparam logic [3:0] OP_MFHI  = 4'b1010;
  localparam logic [3:0] OP_MFLO  = 4'b1011;
  localparam logic [3:0] OP_MULTU = 4'b1100;
  localparam logic [3:0] OP_DIVU  = 4'b1101;

  typedef enum logic [1:0] {
    MDU_IDLE = 2'd0,
    MDU_MUL  = 2'd1,
    MDU_DIV  = 2'd2
  } mdu_state_e;

endpackage
`default_nettype wire

// File: rtl/mdu_iter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mdu_iter : one-bit-per-cycle unsigned shift-add multiplier / restoring divider
// Rev 1.0
// ---------------------------------------------------------------------------
module mdu_iter #(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = $clog2(DATA_WIDTH)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start_mul,
  input  logic                  start_div,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] hi,
  output logic [DATA_WIDTH-1:0] lo
);
  import alu_pkg::*;

  localparam int                   W        = DATA_WIDTH;
  localparam logic [CNT_WIDTH-1:0] LAST_CNT = CNT_WIDTH'(DATA_WIDTH - 1);

  mdu_state_e           state_q;
  logic [CNT_WIDTH-1:0] cnt_q;
  logic [W-1:0]         acc_q, mq_q, opb_q, hi_q, lo_q;
  logic [W-1:0]         acc_d, mq_d;
  logic                 done_q;
  logic [W:0]           mul_sum, div_shift, div_diff;

  // acc_q is the running upper product half / partial remainder;
  // mq_q holds the multiplier (shifted out) or dividend (shifted into quotient).
  always_comb begin
    mul_sum   = {1'b0, acc_q} + (mq_q[0] ? {1'b0, opb_q} : '0);
    div_shift = {acc_q, mq_q[W-1]};
    div_diff  = div_shift - {1'b0, opb_q};
    acc_d     = acc_q;
    mq_d      = mq_q;
    if (state_q == MDU_MUL) begin
      acc_d = mul_sum[W:1];
      mq_d  = {mul_sum[0], mq_q[W-1:1]};
    end else if (state_q == MDU_DIV) begin
      if (div_diff[W]) begin
        acc_d = div_shift[W-1:0];
        mq_d  = {mq_q[W-2:0], 1'b0};
      end else begin
        acc_d = div_diff[W-1:0];
        mq_d  = {mq_q[W-2:0], 1'b1};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= MDU_IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      mq_q    <= '0;
      opb_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        MDU_IDLE: begin
          if (start_mul) begin
            acc_q   <= '0;
            mq_q    <= b;
            opb_q   <= a;
            cnt_q   <= '0;
            state_q <= MDU_MUL;
          end else if (start_div) begin
            acc_q   <= '0;
            mq_q    <= a;
            opb_q   <= b;
            cnt_q   <= '0;
            state_q <= MDU_DIV;
          end
        end
        MDU_MUL, MDU_DIV: begin
          acc_q <= acc_d;
          mq_q  <= mq_d;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == LAST_CNT) begin
            hi_q    <= acc_d;
            lo_q    <= mq_d;
            done_q  <= 1'b1;
            cnt_q   <= '0;
            state_q <= MDU_IDLE;
          end
        end
        default: state_q <= MDU_IDLE;
      endcase
    end
  end

  assign busy = (state_q != MDU_IDLE);
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule
`default_nettype wire

// File: rtl/alu_control_mdu.sv
`default_nettype none
// ---------------------------------------------------------------------------
// alu_control_mdu : ALU control decode plus MULTU/DIVU unit with HI/LO and stall
// Rev 1.0
// ---------------------------------------------------------------------------
module alu_control_mdu #(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = $clog2(DATA_WIDTH)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  Valid,
  input  logic [2:0]            ALUOp,
  input  logic [5:0]            ALUFunction,
  input  logic [DATA_WIDTH-1:0] OperandA,
  input  logic [DATA_WIDTH-1:0] OperandB,
  output logic [3:0]            ALUOperation,
  output logic                  MDUSelect,
  output logic [DATA_WIDTH-1:0] MDUResult,
  output logic                  Stall,
  output logic                  Busy,
  output logic                  Done,
  output logic                  DivByZero
);
  import alu_pkg::*;

  logic [3:0]            op;
  logic                  mdu_op, start_mul, start_div, div_by_zero_q;
  logic [DATA_WIDTH-1:0] hi, lo;

  always_comb begin
    op = OP_NOP;
    if (ALUOp == ALUOP_RTYPE) begin
      case (ALUFunction)
        FUNCT_AND:   op = OP_AND;
        FUNCT_OR:    op = OP_OR;
        FUNCT_NOR:   op = OP_NOR;
        FUNCT_ADD:   op = OP_ADD;
        FUNCT_SUB:   op = OP_SUB;
        FUNCT_SLL:   op = OP_SLL;
        FUNCT_SRL:   op = OP_SRL;
        FUNCT_SLT:   op = OP_SLT;
        FUNCT_MFHI:  op = OP_MFHI;
        FUNCT_MFLO:  op = OP_MFLO;
        FUNCT_MULTU: op = OP_MULTU;
        FUNCT_DIVU:  op = OP_DIVU;
        default:     op = OP_NOP;
      endcase
    end else begin
      case (ALUOp)
        ALUOP_ANDI: op = OP_AND;
        ALUOP_ORI:  op = OP_OR;
        ALUOP_ADDI: op = OP_ADD;
        ALUOP_LUI:  op = OP_LUI;
        default:    op = OP_NOP;
      endcase
    end
  end

  // Only MDU-touching instructions wait; everything else flows past a busy MDU.
  assign mdu_op    = (op == OP_MULTU) || (op == OP_DIVU) || (op == OP_MFHI) || (op == OP_MFLO);
  assign Stall     = Valid & Busy & mdu_op;
  assign start_mul = Valid & ~Busy & (op == OP_MULTU);
  assign start_div = Valid & ~Busy & (op == OP_DIVU);

  assign ALUOperation = op;
  assign MDUSelect    = (op == OP_MFHI) || (op == OP_MFLO);
  assign MDUResult    = (op == OP_MFHI) ? hi : (op == OP_MFLO) ? lo : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      div_by_zero_q <= 1'b0;
    end else if (start_div) begin
      div_by_zero_q <= (OperandB == '0);
    end
  end

  assign DivByZero = div_by_zero_q;

  mdu_iter #(
    .DATA_WIDTH (DATA_WIDTH),
    .CNT_WIDTH  (CNT_WIDTH)
  ) u_mdu (
    .clk       (clk),
    .reset     (reset),
    .start_mul (start_mul),
    .start_div (start_div),
    .a         (OperandA),
    .b         (OperandB),
    .busy      (Busy),
    .done      (Done),
    .hi        (hi),
    .lo        (lo)
  );

endmodule
`default_nettype wire

// File: tb/tb_alu_control_mdu.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_alu_control_mdu : reference-model bench for alu_control_mdu (32- and 8-bit builds)
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_alu_control_mdu;
  localparam int W = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         reset, Valid;
  logic [2:0]   ALUOp;
  logic [5:0]   ALUFunction;
  logic [W-1:0] OperandA, OperandB, MDUResult;
  logic [3:0]   ALUOperation;
  logic         MDUSelect, Stall, Busy, Done, DivByZero;

  logic         v8;
  logic [2:0]   op8;
  logic [5:0]   fn8;
  logic [7:0]   a8, b8, res8;
  logic [3:0]   aluop8;
  logic         sel8, stall8, busy8, done8, dbz8;

  alu_control_mdu #(.DATA_WIDTH(W)) dut (
    .clk(clk), .reset(reset), .Valid(Valid), .ALUOp(ALUOp), .ALUFunction(ALUFunction),
    .OperandA(OperandA), .OperandB(OperandB), .ALUOperation(ALUOperation),
    .MDUSelect(MDUSelect), .MDUResult(MDUResult), .Stall(Stall), .Busy(Busy),
    .Done(Done), .DivByZero(DivByZero)
  );

  alu_control_mdu #(.DATA_WIDTH(8)) dut8 (
    .clk(clk), .reset(reset), .Valid(v8), .ALUOp(op8), .ALUFunction(fn8),
    .OperandA(a8), .OperandB(b8), .ALUOperation(aluop8),
    .MDUSelect(sel8), .MDUResult(res8), .Stall(stall8), .Busy(busy8),
    .Done(done8), .DivByZero(dbz8)
  );

  int n_chk = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [3:0] ref_op(input logic [2:0] op, input logic [5:0] fn);
    if (op != 3'b111) begin
      case (op)
        3'b000:  return 4'b0000;
        3'b001:  return 4'b0001;
        3'b100:  return 4'b0011;
        3'b101:  return 4'b0101;
        default: return 4'b1001;
      endcase
    end
    case (fn)
      6'b100100: return 4'b0000;
      6'b100101: return 4'b0001;
      6'b100111: return 4'b0010;
      6'b100000: return 4'b0011;
      6'b100010: return 4'b0100;
      6'b000000: return 4'b0110;
      6'b000010: return 4'b0111;
      6'b101010: return 4'b1000;
      6'b010000: return 4'b1010;
      6'b010010: return 4'b1011;
      6'b011001: return 4'b1100;
      6'b011011: return 4'b1101;
      default:   return 4'b1001;
    endcase
  endfunction

  // Reference model: cycles left in flight, pending result, architectural HI/LO.
  int           m_rem = 0;
  logic [W-1:0] m_hi, m_lo, p_hi, p_lo;
  bit           m_done, m_dbz;

  always @(posedge clk) begin
    if (reset) begin
      m_rem <= 0; m_hi <= '0; m_lo <= '0; m_done <= 1'b0; m_dbz <= 1'b0;
    end else begin
      m_done <= 1'b0;
      if (m_rem > 0) begin
        m_rem <= m_rem - 1;
        if (m_rem == 1) begin
          m_hi <= p_hi; m_lo <= p_lo; m_done <= 1'b1;
        end
      end else if (Valid && ALUOp == 3'b111 && ALUFunction == 6'b011001) begin
        m_rem <= W;
        {p_hi, p_lo} <= 64'(OperandA) * 64'(OperandB);
      end else if (Valid && ALUOp == 3'b111 && ALUFunction == 6'b011011) begin
        m_rem <= W;
        m_dbz <= (OperandB == 0);
        if (OperandB == 0) begin
          p_lo <= '1; p_hi <= OperandA;
        end else begin
          p_lo <= OperandA / OperandB; p_hi <= OperandA % OperandB;
        end
      end
    end
  end

  logic [3:0]   e_op;
  logic [W-1:0] e_res;
  bit           e_mdu;

  always @(negedge clk) begin
    if (chk_en) begin
      e_op  = ref_op(ALUOp, ALUFunction);
      e_mdu = e_op inside {4'b1010, 4'b1011, 4'b1100, 4'b1101};
      e_res = (e_op == 4'b1010) ? m_hi : (e_op == 4'b1011) ? m_lo : '0;
      chk("ALUOperation", ALUOperation, e_op);
      chk("MDUSelect", MDUSelect, (e_op == 4'b1010) || (e_op == 4'b1011));
      chk("MDUResult", MDUResult, e_res);
      chk("Stall", Stall, Valid && (m_rem > 0) && e_mdu);
      chk("Busy", Busy, m_rem > 0);
      chk("Done", Done, m_done);
      chk("DivByZero", DivByZero, m_dbz);
    end
  end

  task automatic tick;
    @(posedge clk); #1;
  endtask

  task automatic drive(input bit v, input logic [2:0] op, input logic [5:0] fn,
                       input logic [W-1:0] a, input logic [W-1:0] b);
    Valid = v; ALUOp = op; ALUFunction = fn; OperandA = a; OperandB = b;
  endtask

  task automatic wait_idle;
    for (int i = 0; i < 100 && Busy; i++) tick;
    if (Busy) chk("idle_timeout", 1, 0);
  endtask

  task automatic run_mdu(input logic [5:0] fn, input logic [W-1:0] a, input logic [W-1:0] b);
    int k;
    wait_idle;
    drive(1, 3'b111, fn, a, b);
    tick;
    drive(0, 3'b000, 6'b0, '0, '0);
    k = 0;
    while (!Done && k < 100) begin tick; k++; end
    chk("done_seen", Done, 1);
  endtask

  task automatic read_hilo(output logic [W-1:0] hi, output logic [W-1:0] lo);
    drive(1, 3'b111, 6'b010000, '0, '0);
    @(negedge clk); hi = MDUResult;
    tick;
    drive(1, 3'b111, 6'b010010, '0, '0);
    @(negedge clk); lo = MDUResult;
    tick;
    drive(0, 3'b000, 6'b0, '0, '0);
  endtask

  logic [8:0]   sw_in  [16];
  logic [3:0]   sw_exp [16];
  logic [5:0]   fn_tab [14];
  logic [W-1:0] hi, lo;
  int           nb, ns, nd;
  bit           hold;

  initial begin
    sw_in  = '{{3'b111,6'b100100}, {3'b111,6'b100101}, {3'b111,6'b100111}, {3'b111,6'b100000},
               {3'b111,6'b100010}, {3'b111,6'b000000}, {3'b111,6'b000010}, {3'b111,6'b101010},
               {3'b111,6'b111111}, {3'b111,6'b011000}, {3'b000,6'b100010}, {3'b001,6'b101010},
               {3'b100,6'b011001}, {3'b101,6'b000000}, {3'b010,6'b100100}, {3'b110,6'b011011}};
    sw_exp = '{4'b0000, 4'b0001, 4'b0010, 4'b0011, 4'b0100, 4'b0110, 4'b0111, 4'b1000,
               4'b1001, 4'b1001, 4'b0000, 4'b0001, 4'b0011, 4'b0101, 4'b1001, 4'b1001};
    fn_tab = '{6'b100100, 6'b100101, 6'b100111, 6'b100000, 6'b100010, 6'b000000, 6'b000010,
               6'b101010, 6'b010000, 6'b010010, 6'b011001, 6'b011011, 6'b011010, 6'b111111};

    reset = 1'b1;
    drive(0, 3'b000, 6'b0, '0, '0);
    v8 = 1'b0; op8 = 3'b000; fn8 = 6'b0; a8 = '0; b8 = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    chk_en = 1'b1;

    // Reset state
    drive(1, 3'b111, 6'b010000, '0, '0);
    @(negedge clk);
    chk("rst_busy", Busy, 0);
    chk("rst_done", Done, 0);
    chk("rst_dbz", DivByZero, 0);
    chk("rst_stall", Stall, 0);
    chk("rst_hi", MDUResult, 0);
    tick;

    // Legacy decode sweep
    for (int i = 0; i < 16; i++) begin
      drive(1, sw_in[i][8:6], sw_in[i][5:0], 32'h1234, 32'h5678);
      @(negedge clk);
      chk($sformatf("sweep_%0d", i), ALUOperation, sw_exp[i]);
      chk($sformatf("sweep_busy_%0d", i), Busy, 0);
      tick;
    end
    drive(0, 3'b000, 6'b0, '0, '0);

    // MULTU all-ones, ADD at E5, MFLO from E6, MFHI after completion
    drive(1, 3'b111, 6'b011001, '1, '1);
    tick;
    drive(0, 3'b000, 6'b0, '0, '0);
    nb = 0; ns = 0;
    for (int k = 0; k < 36; k++) begin
      @(negedge clk);
      if (Busy) nb++;
      if (Stall) ns++;
      if (k == 5) begin
        chk("add_stall", Stall, 0);
        chk("add_op", ALUOperation, 4'b0011);
      end
      if (k == 32) begin
        chk("mflo_post_stall", Stall, 0);
        chk("mul_done", Done, 1);
        chk("mul_lo", MDUResult, 32'h00000001);
      end
      if (k == 33) begin
        chk("mfhi_stall", Stall, 0);
        chk("mul_hi", MDUResult, 32'hFFFFFFFE);
      end
      tick;
      if (k + 1 == 5)                  drive(1, 3'b111, 6'b100000, 32'd1, 32'd2);
      else if (k + 1 >= 6 && k + 1 <= 32) drive(1, 3'b111, 6'b010010, '0, '0);
      else if (k + 1 == 33)            drive(1, 3'b111, 6'b010000, '0, '0);
      else                             drive(0, 3'b000, 6'b0, '0, '0);
    end
    chk("mul_busy_cycles", nb, 32);
    chk("mflo_stall_cycles", ns, 26);

    // Division cases
    run_mdu(6'b011011, 32'd100, 32'd7);
    read_hilo(hi, lo);
    chk("div_lo", lo, 14);
    chk("div_hi", hi, 2);
    run_mdu(6'b011011, 32'd5, 32'd0);
    read_hilo(hi, lo);
    chk("div0_lo", lo, 32'hFFFFFFFF);
    chk("div0_hi", hi, 5);
    chk("div0_flag", DivByZero, 1);
    run_mdu(6'b011011, 32'd8, 32'd2);
    chk("div0_cleared", DivByZero, 0);
    read_hilo(hi, lo);
    chk("div82_lo", lo, 4);
    chk("div82_hi", hi, 0);

    // Reset at E10 of a DIVU
    wait_idle;
    drive(1, 3'b111, 6'b011011, 32'd1000, 32'd3);
    tick;
    drive(0, 3'b000, 6'b0, '0, '0);
    repeat (9) tick;
    reset = 1'b1;
    tick;
    reset = 1'b0;
    @(negedge clk);
    chk("abort_busy", Busy, 0);
    chk("abort_done", Done, 0);
    nd = 0;
    for (int k = 0; k < 40; k++) begin
      tick;
      @(negedge clk);
      if (Done) nd++;
    end
    chk("abort_no_done", nd, 0);
    tick;
    read_hilo(hi, lo);
    chk("abort_hi", hi, 0);
    chk("abort_lo", lo, 0);
    run_mdu(6'b011001, 32'd3, 32'd4);
    read_hilo(hi, lo);
    chk("mul34_lo", lo, 12);
    chk("mul34_hi", hi, 0);

    // Randomized traffic; a stalled instruction is held until accepted
    hold = 1'b0;
    for (int i = 0; i < 700; i++) begin
      if (!hold) begin
        Valid       = ($urandom_range(0, 4) != 0);
        ALUOp       = ($urandom_range(0, 3) == 0) ? 3'($urandom) : 3'b111;
        ALUFunction = ($urandom_range(0, 2) == 0) ? fn_tab[$urandom_range(10, 11)]
                                                  : fn_tab[$urandom_range(0, 13)];
        OperandA    = ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 300)) : W'($urandom);
        OperandB    = ($urandom_range(0, 4) == 0) ? W'($urandom_range(0, 9))   : W'($urandom);
      end
      @(negedge clk);
      hold = Stall;
      tick;
    end
    drive(0, 3'b000, 6'b0, '0, '0);
    wait_idle;

    // 8-bit build
    v8 = 1'b1; op8 = 3'b111; fn8 = 6'b011001; a8 = 8'hFF; b8 = 8'hFF;
    tick;
    v8 = 1'b0;
    nb = 0; nd = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (busy8) nb++;
      if (done8) nd++;
      tick;
    end
    chk("w8_busy_cycles", nb, 8);
    chk("w8_done_pulses", nd, 1);
    v8 = 1'b1; fn8 = 6'b010000;
    @(negedge clk);
    chk("w8_hi", res8, 8'hFE);
    tick;
    fn8 = 6'b010010;
    @(negedge clk);
    chk("w8_lo", res8, 8'h01);
    tick;
    v8 = 1'b0;

    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
